mux_rr_n: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It selects either one externally chosen channel or the next requester in round-robin order, and registers the winning word with its channel index. It is the sequential successor to the combinational 4:1 mux and sits between multiple producer streams and a single consumer.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/mux_rr_n.sv | 83 ++++++++
 tb/tb_mux_rr_n.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and width helper for the registered round-robin mux family.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests past ptr, pick the lowest, rotate back.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = clog2_safe(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic          grant_valid,
    output logic [CW-1:0] grant_idx
);

    logic [N-1:0] rot;
    int unsigned  start;
    int unsigned  pos;
    int unsigned  hit;

    always_comb begin
        // Search starts one past the last served channel, wrapping at N (N need not be 2^k).
        start = (32'(ptr) + 32'd1 >= N) ? 32'd0 : 32'(ptr) + 32'd1;
        rot   = '0;
        pos   = 32'd0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = start + i;
            if (pos >= N) pos = pos - N;
            rot[i] = req[CW'(pos)];
        end

        grant_valid = 1'b0;
        hit         = 32'd0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!grant_valid && rot[i]) begin
                grant_valid = 1'b1;
                hit         = i;
            end
        end

        pos = start + hit;
        if (pos >= N) pos = pos - N;
        grant_idx = CW'(pos);
    end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel registered mux with valid/ready on every port; external-select or round-robin grant.
module mux_rr_n
    import mux_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 8,
    parameter int unsigned CW = clog2_safe(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [CW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_ch,
    input  logic           out_ready
);

    logic [CW-1:0] ptr;
    logic          arb_valid;
    logic [CW-1:0] arb_idx;
    logic          load_c;
    logic          grant_valid_c;
    logic [CW-1:0] grant_idx_c;
    logic          xfer_c;
    logic [W-1:0]  win_data_c;

    rr_arbiter #(.N(N), .CW(CW)) u_arb (
        .req         (in_valid),
        .ptr         (ptr),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    assign load_c = !out_valid || out_ready;

    // Grant source: arbiter in RR mode, range-checked sel otherwise.
    always_comb begin
        grant_valid_c = 1'b0;
        grant_idx_c   = arb_idx;
        if (mode == MODE_RR) begin
            grant_valid_c = arb_valid;
        end else begin
            grant_idx_c = sel;
            if (32'(sel) < N) grant_valid_c = in_valid[sel];
        end
    end

    assign xfer_c = load_c && grant_valid_c;

    // One-hot accept; held low while reset is asserted.
    always_comb begin
        in_ready   = '0;
        win_data_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx_c == CW'(i)) begin
                in_ready[i] = rst_n && xfer_c;
                win_data_c  = in_data[i*W +: W];
            end
        end
    end

    // Output word, its source channel and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= CW'(N - 1);
        end else if (xfer_c) begin
            out_valid <= 1'b1;
            out_data  <= win_data_c;
            out_ch    <= grant_idx_c;
            ptr       <= grant_idx_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n (N=4, W=8) with a cycle-level reference model.
module tb_mux_rr_n;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned CW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mode;
    logic [CW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_ch;
    logic           out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    mux_rr_n #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: output slot, source channel and last-served channel.
    int m_valid, m_data, m_ch, m_ptr;
    int n_valid, n_data, n_ch, n_ptr;
    int g, c;
    bit ld;
    logic [N-1:0] exp_rdy;

    initial begin
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = N - 1;
        forever begin
            @(negedge clk);
            exp_rdy = '0;
            if (!rst_n) begin
                m_valid = 0; m_data = 0; m_ch = 0; m_ptr = N - 1;
            end
            n_valid = m_valid; n_data = m_data; n_ch = m_ch; n_ptr = m_ptr;
            if (rst_n) begin
                ld = (m_valid == 0) || out_ready;
                g  = -1;
                if (mode == 1'b0) begin
                    if (int'(sel) < N && in_valid[sel]) g = int'(sel);
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        c = (m_ptr + k) % N;
                        if (g < 0 && in_valid[c]) g = c;
                    end
                end
                if (ld && g >= 0) begin
                    exp_rdy[g] = 1'b1;
                    n_valid = 1;
                    n_data  = int'(in_data[g*W +: W]);
                    n_ch    = g;
                    n_ptr   = g;
                end else if (out_ready) begin
                    n_valid = 0;
                end
            end
            check("model_out_valid", 32'(out_valid), 32'(m_valid));
            check("model_out_data",  32'(out_data),  32'(m_data));
            check("model_out_ch",    32'(out_ch),    32'(m_ch));
            check("model_in_ready",  32'(in_ready),  32'(exp_rdy));
            check("model_ptr",       32'(dut.ptr),   32'(m_ptr));
            @(posedge clk);
            m_valid = n_valid; m_data = n_data; m_ch = n_ch; m_ptr = n_ptr;
        end
    end

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        out_ready = 1'b1;

        // Reset and idle
        repeat (3) step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_data",  32'(out_data),  32'h00);
            check("idle_ch",    32'(out_ch),    32'd0);
            check("idle_ready", 32'(in_ready),  32'b0000);
        end

        // SEL sweep
        in_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            sel = CW'(k);
            step();
            check("sel_data", 32'(out_data), 32'h11 * (k + 1));
            check("sel_ch",   32'(out_ch),   32'(k));
        end
        sel = 2'd2;
        in_valid = 4'b1011;
        #1;
        check("sel_invalid_ready", 32'(in_ready), 32'b0000);
        step();
        check("sel_invalid_valid", 32'(out_valid), 32'd0);
        check("sel_invalid_hold",  32'(out_data),  32'h44);

        // RR fairness, then sparse requests
        mode = 1'b1;
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_fair_ch", 32'(out_ch), 32'(k % 4));
        end
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_sparse_ch", 32'(out_ch), (k % 2 == 1) ? 32'd3 : 32'd1);
        end

        // Backpressure
        in_valid = 4'b0000;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        in_valid = 4'b1111;
        step();
        check("bp_first_ch", 32'(out_ch), 32'd0);
        out_ready = 1'b0;
        #1;
        check("bp_ready_low", 32'(in_ready), 32'b0000);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data",  32'(out_data),  32'h11);
            check("bp_ch",    32'(out_ch),    32'd0);
            check("bp_ptr",   32'(dut.ptr),   32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'b0010);
        step();
        check("bp_next_data", 32'(out_data), 32'h22);
        check("bp_next_ch",   32'(out_ch),   32'd1);

        // Mode switch mid-stream
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("ms_ch0", 32'(out_ch), 32'd0);
        step();
        check("ms_ch1", 32'(out_ch), 32'd1);
        mode = 1'b0;
        sel  = 2'd3;
        step();
        check("ms_ch3",  32'(out_ch),   32'd3);
        check("ms_d3",   32'(out_data), 32'h44);
        mode = 1'b1;
        step();
        check("ms_ch0b", 32'(out_ch), 32'd0);

        // Async reset mid-operation
        mode = 1'b0;
        sel  = 2'd2;
        step();
        check("ar_load", 32'(out_data), 32'h33);
        out_ready = 1'b0;
        step();
        check("ar_hold_valid", 32'(out_valid), 32'd1);
        check("ar_hold_data",  32'(out_data),  32'h33);
        #2;
        rst_n    = 1'b0;
        in_valid = 4'b0000;
        #1;
        check("ar_valid_now", 32'(out_valid), 32'd0);
        check("ar_ready_now", 32'(in_ready),  32'b0000);
        check("ar_data_now",  32'(out_data),  32'h00);
        #3;
        rst_n = 1'b1;
        step();
        check("ar_after_valid", 32'(out_valid), 32'd0);
        mode      = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        step();
        check("ar_first_ch",   32'(out_ch),   32'd0);
        check("ar_first_data", 32'(out_data), 32'h11);

        in_valid = 4'b0000;
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
